// File: rtl/dvi_pkg.sv
// dvi_pkg -- shared definitions for the DVI timing generator.
//   * 640x480@60 default timing constants
//   * TMDS control-period code words
//   * rgb_t pixel struct and the 8-bar colour lookup used by dvi_bar_pattern
package dvi_pkg;

   localparam int DVI_H_ACTIVE = 640;
   localparam int DVI_H_FP     = 16;
   localparam int DVI_H_SYNC   = 96;
   localparam int DVI_H_BP     = 48;
   localparam int DVI_V_ACTIVE = 480;
   localparam int DVI_V_FP     = 10;
   localparam int DVI_V_SYNC   = 2;
   localparam int DVI_V_BP     = 33;

   // 10-bit TMDS words sent during control periods, indexed by {c1, c0}
   localparam logic [9:0] TMDS_CTL_00 = 10'b1101010100;
   localparam logic [9:0] TMDS_CTL_01 = 10'b0010101011;
   localparam logic [9:0] TMDS_CTL_10 = 10'b0101010100;
   localparam logic [9:0] TMDS_CTL_11 = 10'b1010101011;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Bar colours left to right: white, yellow, cyan, green, magenta, red, blue, black
   function automatic rgb_t bar_colour(input logic [2:0] idx);
      rgb_t c;
      case (idx)
         3'd0:    c = {8'hFF, 8'hFF, 8'hFF};
         3'd1:    c = {8'hFF, 8'hFF, 8'h00};
         3'd2:    c = {8'h00, 8'hFF, 8'hFF};
         3'd3:    c = {8'h00, 8'hFF, 8'h00};
         3'd4:    c = {8'hFF, 8'h00, 8'hFF};
         3'd5:    c = {8'hFF, 8'h00, 8'h00};
         3'd6:    c = {8'h00, 8'h00, 8'hFF};
         default: c = {8'h00, 8'h00, 8'h00};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/dvi_bar_pattern.sv
// dvi_bar_pattern -- combinational 8-bar colour test pattern.
//   x       in  12  pixel column of the requested pixel
//   r/g/b   out 8   bar colour for that column
// Bars are H_ACTIVE/8 wide; the last (black) bar absorbs any remainder.
module dvi_bar_pattern
   import dvi_pkg::*;
#(
   parameter int H_ACTIVE = DVI_H_ACTIVE
) (
   input  logic [11:0] x,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b
);

   // Guard against a zero-width bar on very narrow test timings
   localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

   logic [11:0] bar_idx_s;
   rgb_t        colour_s;

   // Column to bar index, clamped so the remainder lands in the last bar
   always_comb begin
      bar_idx_s = x / 12'(BAR_W);
      if (bar_idx_s > 12'd7) begin
         colour_s = bar_colour(3'd7);
      end else begin
         colour_s = bar_colour(bar_idx_s[2:0]);
      end
   end

   assign r = colour_s.r;
   assign g = colour_s.g;
   assign b = colour_s.b;

endmodule

// File: rtl/dvi_timing_gen.sv
// dvi_timing_gen -- DVI/TMDS video timing generator.
// Optional feature macro: DVI_TEST_PATTERN_EN (adds pat_en and the colour-bar source).
// Ports:
//   pix_clk, rst          pixel clock, synchronous active-high reset
//   en                    run enable; low holds the raster at (0,0)
//   pat_en                (DVI_TEST_PATTERN_EN only) select colour bars over in_*
//   in_r/in_g/in_b        upstream pixel, sampled in the req cycle
//   req, x, y             combinational pixel request and its coordinate
//   frame_start/line_start one-cycle pulses aligned with req
//   de, ctl0, r/g/b       registered encoder inputs, one cycle after req
//   ctl1, ctl2            green/red control, constant 2'b00
module dvi_timing_gen
   import dvi_pkg::*;
#(
   parameter int H_ACTIVE = DVI_H_ACTIVE,
   parameter int H_FP     = DVI_H_FP,
   parameter int H_SYNC   = DVI_H_SYNC,
   parameter int H_BP     = DVI_H_BP,
   parameter int V_ACTIVE = DVI_V_ACTIVE,
   parameter int V_FP     = DVI_V_FP,
   parameter int V_SYNC   = DVI_V_SYNC,
   parameter int V_BP     = DVI_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic        pix_clk,
   input  logic        rst,
   input  logic        en,
`ifdef DVI_TEST_PATTERN_EN
   input  logic        pat_en,
`endif
   input  logic [7:0]  in_r,
   input  logic [7:0]  in_g,
   input  logic [7:0]  in_b,
   output logic        req,
   output logic [11:0] x,
   output logic [11:0] y,
   output logic        de,
   output logic [1:0]  ctl0,
   output logic [1:0]  ctl1,
   output logic [1:0]  ctl2,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        frame_start,
   output logic        line_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 4096 || V_TOTAL > 4096 ||
       H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
      $error("dvi_timing_gen: timing parameters out of range");
   end

   // Segment boundaries; all below 4096 once the totals are legal
   localparam logic [11:0] H_ACT_L  = 12'(H_ACTIVE);
   localparam logic [11:0] HS_BEG_L = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END_L = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_LAST_L = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_ACT_L  = 12'(V_ACTIVE);
   localparam logic [11:0] VS_BEG_L = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END_L = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_LAST_L = 12'(V_TOTAL - 1);

   localparam logic [1:0]  CTL0_IDLE = {~VS_POL, ~HS_POL};

   logic [11:0] hcnt_q, hcnt_d;
   logic [11:0] vcnt_q, vcnt_d;
   logic        de_q;
   logic [1:0]  ctl0_q;
   logic [7:0]  r_q, g_q, b_q;

   logic        req_s;
   logic        hs_act_s;
   logic        vs_act_s;
   logic [7:0]  pix_r_s, pix_g_s, pix_b_s;

   // Raster counter next state; dropping en aborts the frame back to (0,0)
   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (!en) begin
         hcnt_d = 12'd0;
         vcnt_d = 12'd0;
      end else if (hcnt_q == H_LAST_L) begin
         hcnt_d = 12'd0;
         if (vcnt_q == V_LAST_L) begin
            vcnt_d = 12'd0;
         end else begin
            vcnt_d = vcnt_q + 12'd1;
         end
      end else begin
         hcnt_d = hcnt_q + 12'd1;
      end
   end

   // Raster counters
   always_ff @(posedge pix_clk) begin
      if (rst) begin
         hcnt_q <= 12'd0;
         vcnt_q <= 12'd0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   // Gating with en keeps the request and pulses quiet while the counters idle at 0
   assign req_s       = en & (hcnt_q < H_ACT_L) & (vcnt_q < V_ACT_L);
   assign hs_act_s    = en & (hcnt_q >= HS_BEG_L) & (hcnt_q < HS_END_L);
   assign vs_act_s    = en & (vcnt_q >= VS_BEG_L) & (vcnt_q < VS_END_L);
   assign req         = req_s;
   assign x           = req_s ? hcnt_q : 12'd0;
   assign y           = req_s ? vcnt_q : 12'd0;
   assign frame_start = en & (hcnt_q == 12'd0) & (vcnt_q == 12'd0);
   assign line_start  = en & (hcnt_q == 12'd0);

`ifdef DVI_TEST_PATTERN_EN
   logic [7:0] bar_r_s, bar_g_s, bar_b_s;

   dvi_bar_pattern #(
      .H_ACTIVE (H_ACTIVE)
   ) u_bar (
      .x (x),
      .r (bar_r_s),
      .g (bar_g_s),
      .b (bar_b_s)
   );

   assign pix_r_s = pat_en ? bar_r_s : in_r;
   assign pix_g_s = pat_en ? bar_g_s : in_g;
   assign pix_b_s = pat_en ? bar_b_s : in_b;
`else
   assign pix_r_s = in_r;
   assign pix_g_s = in_g;
   assign pix_b_s = in_b;
`endif

   // Encoder-facing stage: everything here lags req by exactly one cycle
   always_ff @(posedge pix_clk) begin
      if (rst) begin
         de_q   <= 1'b0;
         ctl0_q <= CTL0_IDLE;
         r_q    <= 8'd0;
         g_q    <= 8'd0;
         b_q    <= 8'd0;
      end else begin
         de_q   <= req_s;
         ctl0_q <= {(vs_act_s ? VS_POL : ~VS_POL), (hs_act_s ? HS_POL : ~HS_POL)};
         r_q    <= req_s ? pix_r_s : 8'd0;
         g_q    <= req_s ? pix_g_s : 8'd0;
         b_q    <= req_s ? pix_b_s : 8'd0;
      end
   end

   assign de   = de_q;
   assign ctl0 = ctl0_q;
   assign ctl1 = 2'b00;
   assign ctl2 = 2'b00;
   assign r    = r_q;
   assign g    = g_q;
   assign b    = b_q;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Directed bench for dvi_timing_gen on a 14x7 (98-cycle) raster.
// Pixels requested are pushed to a scoreboard; a monitor pops one per de cycle.
`timescale 1ns/1ps
module tb_dvi_timing_gen;

   localparam int HA = 8, HF = 2, HS = 2, HB = 2;
   localparam int VA = 4, VF = 1, VS = 1, VB = 1;
   localparam int HT = 14, VT = 7;

   logic        pix_clk = 1'b0;
   logic        rst, en;
   logic [7:0]  in_r, in_g, in_b;
   logic        req, de, frame_start, line_start;
   logic [11:0] x, y;
   logic [1:0]  ctl0, ctl1, ctl2;
   logic [7:0]  r, g, b;

   int          errors = 0;
   int          checks = 0;
   bit          mon_on = 1'b0;
   logic [23:0] exp_q[$];

   always #5 pix_clk = ~pix_clk;

   // Upstream source: r = x+1, g = y+16, b constant
   assign in_r = x[7:0] + 8'd1;
   assign in_g = y[7:0] + 8'h10;
   assign in_b = 8'hA5;

`ifdef DVI_TEST_PATTERN_EN
   logic pat_en = 1'b0;
`endif

   dvi_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .pix_clk(pix_clk), .rst(rst), .en(en),
`ifdef DVI_TEST_PATTERN_EN
      .pat_en(pat_en),
`endif
      .in_r(in_r), .in_g(in_g), .in_b(in_b),
      .req(req), .x(x), .y(y), .de(de),
      .ctl0(ctl0), .ctl1(ctl1), .ctl2(ctl2),
      .r(r), .g(g), .b(b),
      .frame_start(frame_start), .line_start(line_start)
   );

`ifdef DVI_TEST_PATTERN_EN
   logic        en_p = 1'b0;
   logic        p_req, p_de, p_fs, p_ls;
   logic [11:0] p_x, p_y;
   logic [1:0]  p_c0, p_c1, p_c2;
   logic [7:0]  p_r, p_g, p_b;

   dvi_timing_gen #(
      .H_ACTIVE(16), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut_pat (
      .pix_clk(pix_clk), .rst(rst), .en(en_p), .pat_en(1'b1),
      .in_r(8'h12), .in_g(8'h34), .in_b(8'h56),
      .req(p_req), .x(p_x), .y(p_y), .de(p_de),
      .ctl0(p_c0), .ctl1(p_c1), .ctl2(p_c2),
      .r(p_r), .g(p_g), .b(p_b),
      .frame_start(p_fs), .line_start(p_ls)
   );
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: one queued pixel per de cycle, black otherwise
   always @(negedge pix_clk) begin
      if (mon_on) begin
         if (de === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow actual=%0h required=none at %0t", {r, g, b}, $time);
            end else begin
               check("pixel", {8'h00, r, g, b}, {8'h00, exp_q.pop_front()});
            end
         end else begin
            check("rgb_idle", {8'h00, r, g, b}, 32'd0);
         end
      end
   end

   // Timing model state and observations
   int   mh = 0, mv = 0;
   bit   m_req = 1'b0, m_hs = 1'b0, m_vs = 1'b0;
   int   t = 0;
   bit   obs_on = 1'b0;
   int   fs_cyc[$];
   int   hs_cyc[$];
   int   vs_first = -1, vs_last = -1;
   int   de_cnt[2] = '{0, 0};
   logic l_req, l_de, l_fs;
   logic [1:0] l_ctl0;

   task automatic step();
      bit e_req;
      @(negedge pix_clk);
      e_req = en && (mh < HA) && (mv < VA);
      check("req", req, e_req);
      check("x", x, e_req ? mh : 0);
      check("y", y, e_req ? mv : 0);
      check("frame_start", frame_start, en && mh == 0 && mv == 0);
      check("line_start", line_start, en && mh == 0);
      check("de", de, m_req);
      check("ctl0", ctl0, {~m_vs, ~m_hs});
      check("ctl12", {ctl1, ctl2}, 4'd0);
      if (e_req && !rst) exp_q.push_back({8'(mh + 1), 8'(mv + 16), 8'hA5});
      l_req = req; l_de = de; l_fs = frame_start; l_ctl0 = ctl0;
      if (obs_on) begin
         if (frame_start) fs_cyc.push_back(t);
         if (t < HT && ctl0[0] == 1'b0) hs_cyc.push_back(t);
         if (t < 98 && ctl0[1] == 1'b0) begin
            if (vs_first < 0) vs_first = t;
            vs_last = t;
         end
         if (de && t >= 1 && t <= 196) de_cnt[(t - 1) / 98]++;
      end
      @(posedge pix_clk);
      if (rst || !en) begin
         mh = 0; mv = 0; m_req = 1'b0; m_hs = 1'b0; m_vs = 1'b0;
      end else begin
         m_req = e_req;
         m_hs  = (mh >= HA + HF) && (mh < HA + HF + HS);
         m_vs  = (mv >= VA + VF) && (mv < VA + VF + VS);
         if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else begin
            mh++;
         end
      end
      t++;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      repeat (2) @(posedge pix_clk);
      #1;
      mon_on = 1'b1;

      // Reset state
      step();
      check("rst_de", l_de, 1'b0);
      check("rst_ctl0", l_ctl0, 2'b11);
      check("rst_req", l_req, 1'b0);

      // Two full frames plus the first cycle of the third
      rst = 1'b0; en = 1'b1; t = 0; obs_on = 1'b1;
      for (int i = 0; i <= 196; i++) step();
      obs_on = 1'b0;
      check("fs_count", fs_cyc.size(), 3);
      if (fs_cyc.size() == 3) begin
         check("fs_cyc0", fs_cyc[0], 0);
         check("fs_cyc1", fs_cyc[1], 98);
         check("fs_cyc2", fs_cyc[2], 196);
      end
      // hsync covers hcnt 10-11, seen on ctl0 one cycle later
      check("hs_count", hs_cyc.size(), 2);
      if (hs_cyc.size() == 2) begin
         check("hs_cyc0", hs_cyc[0], 11);
         check("hs_cyc1", hs_cyc[1], 12);
      end
      // vsync covers counter cycles 70-83 (vcnt=5)
      check("vs_first", vs_first, 71);
      check("vs_last", vs_last, 84);
      check("de_frame0", de_cnt[0], 32);
      check("de_frame1", de_cnt[1], 32);

      // Third frame: drop en at cycle 40
      for (int i = 1; i <= 39; i++) step();
      en = 1'b0;
      step();
      step();
      check("en_off_req", l_req, 1'b0);
      check("en_off_de", l_de, 1'b0);
      check("en_off_ctl0", l_ctl0, 2'b11);
      en = 1'b1;
      step();
      check("en_on_fs", l_fs, 1'b1);

      // Reset while hsync is showing on ctl0
      for (int i = 1; i <= 10; i++) step();
      rst = 1'b1;
      step();
      check("hs_before_rst", l_ctl0, 2'b10);
      rst = 1'b0;
      step();
      check("after_rst_ctl0", l_ctl0, 2'b11);
      check("after_rst_de", l_de, 1'b0);
      check("after_rst_fs", l_fs, 1'b1);
      for (int i = 0; i < 20; i++) step();
      en = 1'b0;
      repeat (3) step();
      check("sb_drained", exp_q.size(), 0);

`ifdef DVI_TEST_PATTERN_EN
      begin
         logic [23:0] pix[16];
         int k = 0;
         rst = 1'b1;
         @(posedge pix_clk); #1;
         rst = 1'b0; en_p = 1'b1;
         for (int c = 0; c < 60 && k < 16; c++) begin
            @(negedge pix_clk);
            if (p_de) begin
               pix[k] = {p_r, p_g, p_b};
               k++;
            end
         end
         check("pat_count", k, 16);
         if (k == 16) begin
            check("pat0", pix[0], 24'hFFFFFF);
            check("pat1", pix[1], 24'hFFFFFF);
            check("pat2", pix[2], 24'hFFFF00);
            check("pat3", pix[3], 24'hFFFF00);
            check("pat4", pix[4], 24'h00FFFF);
            check("pat14", pix[14], 24'h000000);
            check("pat15", pix[15], 24'h000000);
         end
         en_p = 1'b0;
      end
`endif

      mon_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
